// File: rtl/gty_ctrl_pkg.sv
// Shared state encodings, default timing and output decode for the GTY reset sequencer.
package gty_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_PG    = 3'd0,
        RST_ALL    = 3'd1,
        WAIT_PMA   = 3'd2,
        SETTLE     = 3'd3,
        WAIT_DONE  = 3'd4,
        UP         = 3'd5,
        RX_RECOVER = 3'd6,
        FAULT      = 3'd7
    } gty_state_t;

    localparam int DEF_RESET_PULSE_CYCLES   = 16;
    localparam int DEF_USRCLK_SETTLE_CYCLES = 64;
    localparam int DEF_PMA_TIMEOUT_CYCLES   = 1000000;
    localparam int DEF_DONE_TIMEOUT_CYCLES  = 4000000;
    localparam int DEF_MAX_RETRIES          = 3;
    localparam int DEF_CNT_W                = 24;

    typedef struct packed {
        logic reset_all;
        logic tx_pll_dp;
        logic rx_pll_dp;
        logic rx_dp;
        logic usrclk_active;
        logic link_up;
        logic fault;
    } gty_outs_t;

    // Steady-state output levels for a state; transient pulses are layered on top by the FSM.
    function automatic gty_outs_t state_outs(gty_state_t s);
        gty_outs_t o;
        o               = '0;
        o.reset_all     = (s == WAIT_PG) || (s == RST_ALL) || (s == FAULT);
        o.tx_pll_dp     = (s == RST_ALL);
        o.rx_pll_dp     = (s == RST_ALL);
        o.usrclk_active = (s == WAIT_DONE) || (s == UP) || (s == RX_RECOVER);
        o.link_up       = (s == UP);
        o.fault         = (s == FAULT);
        return o;
    endfunction

    function automatic logic [3:0] sat_inc4(logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/gty_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (master) and the GTY wizard plus status logic (slave).
interface gty_reset_sequencer_if;

    logic       sw_reset_req;
    logic       gtpowergood_in;
    logic       txpmaresetdone_in;
    logic       rxpmaresetdone_in;
    logic       gtwiz_reset_tx_done_in;
    logic       gtwiz_reset_rx_done_in;
    logic       gtwiz_reset_rx_cdr_stable_in;
    logic       gtwiz_reset_all_out;
    logic       gtwiz_reset_tx_pll_and_datapath_out;
    logic       gtwiz_reset_rx_pll_and_datapath_out;
    logic       gtwiz_reset_tx_datapath_out;
    logic       gtwiz_reset_rx_datapath_out;
    logic       gtwiz_userclk_tx_active_out;
    logic       gtwiz_userclk_rx_active_out;
    logic       link_up;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] state_out;
    logic       rx_cdr_stable;

    modport master (
        input  sw_reset_req, gtpowergood_in, txpmaresetdone_in, rxpmaresetdone_in,
               gtwiz_reset_tx_done_in, gtwiz_reset_rx_done_in, gtwiz_reset_rx_cdr_stable_in,
        output gtwiz_reset_all_out, gtwiz_reset_tx_pll_and_datapath_out,
               gtwiz_reset_rx_pll_and_datapath_out, gtwiz_reset_tx_datapath_out,
               gtwiz_reset_rx_datapath_out, gtwiz_userclk_tx_active_out,
               gtwiz_userclk_rx_active_out, link_up, fault, retry_count, state_out, rx_cdr_stable
    );

    modport slave (
        output sw_reset_req, gtpowergood_in, txpmaresetdone_in, rxpmaresetdone_in,
               gtwiz_reset_tx_done_in, gtwiz_reset_rx_done_in, gtwiz_reset_rx_cdr_stable_in,
        input  gtwiz_reset_all_out, gtwiz_reset_tx_pll_and_datapath_out,
               gtwiz_reset_rx_pll_and_datapath_out, gtwiz_reset_tx_datapath_out,
               gtwiz_reset_rx_datapath_out, gtwiz_userclk_tx_active_out,
               gtwiz_userclk_rx_active_out, link_up, fault, retry_count, state_out, rx_cdr_stable
    );

endinterface

// File: rtl/gty_reset_sequencer_sync_2ff.sv
// Plain two-flop synchronizer bank for level signals crossing into the free-running clock domain.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            // stage 0 -> stage 1
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/gty_reset_sequencer.sv
// Bring-up / recovery sequencer for one GTY channel behind gtwizard_ultrascale_0, with bounded retries.
module gty_reset_sequencer
    import gty_ctrl_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES   = DEF_RESET_PULSE_CYCLES,
    parameter int USRCLK_SETTLE_CYCLES = DEF_USRCLK_SETTLE_CYCLES,
    parameter int PMA_TIMEOUT_CYCLES   = DEF_PMA_TIMEOUT_CYCLES,
    parameter int DONE_TIMEOUT_CYCLES  = DEF_DONE_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES          = DEF_MAX_RETRIES,
    parameter int CNT_W                = DEF_CNT_W
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    gty_reset_sequencer_if.master gt
);

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(USRCLK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PMA_TO      = CNT_W'(PMA_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] DONE_TO     = CNT_W'(DONE_TIMEOUT_CYCLES);
    localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

    logic [5:0] async_vec;
    logic [5:0] sync_vec;
    logic       pg_s, txpma_s, rxpma_s, txd_s, rxd_s, cdr_s;

    assign async_vec = {gt.gtwiz_reset_rx_cdr_stable_in, gt.gtwiz_reset_rx_done_in,
                        gt.gtwiz_reset_tx_done_in, gt.rxpmaresetdone_in,
                        gt.txpmaresetdone_in, gt.gtpowergood_in};

    sync_2ff #(.WIDTH(6), .RESET_VAL(6'b0)) u_sync (
        .clk   (aclk),
        .rst_n (aresetn),
        .d     (async_vec),
        .q     (sync_vec)
    );

    assign {cdr_s, rxd_s, txd_s, rxpma_s, txpma_s, pg_s} = sync_vec;

    // Request path resets high so a request held through reset is not seen as a new edge.
    logic sw_meta_p0, sw_sync_p1, sw_prev_p2;
    logic sw_rise;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sw_meta_p0 <= 1'b1;
            sw_sync_p1 <= 1'b1;
            sw_prev_p2 <= 1'b1;
        end else begin
            sw_meta_p0 <= gt.sw_reset_req;
            sw_sync_p1 <= sw_meta_p0;
            sw_prev_p2 <= sw_sync_p1;
        end
    end

    assign sw_rise = sw_sync_p1 & ~sw_prev_p2;

    gty_state_t       state_q;
    gty_outs_t        outs_q;
    logic [3:0]       retry_q;
    logic [CNT_W-1:0] timer_q;
    logic             rx_pulse_q;

    logic [CNT_W-1:0] timer_inc;
    logic [3:0]       retry_inc;
    gty_state_t       fail_state;

    assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
    assign retry_inc  = sat_inc4(retry_q);
    assign fail_state = (retry_inc >= MAX_R) ? FAULT : RST_ALL;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= WAIT_PG;
            outs_q     <= state_outs(WAIT_PG);
            retry_q    <= '0;
            timer_q    <= '0;
            rx_pulse_q <= 1'b0;
        end else begin
            timer_q <= timer_inc;
            if (sw_rise) begin
                state_q    <= RST_ALL;
                outs_q     <= state_outs(RST_ALL);
                retry_q    <= '0;
                timer_q    <= '0;
                rx_pulse_q <= 1'b0;
            end else if (!pg_s && state_q != WAIT_PG && state_q != FAULT) begin
                state_q    <= WAIT_PG;
                outs_q     <= state_outs(WAIT_PG);
                timer_q    <= '0;
                rx_pulse_q <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_PG: if (pg_s) begin
                        state_q <= RST_ALL;
                        outs_q  <= state_outs(RST_ALL);
                        timer_q <= '0;
                    end
                    RST_ALL: if (timer_q >= PULSE_LAST) begin
                        state_q <= WAIT_PMA;
                        outs_q  <= state_outs(WAIT_PMA);
                        timer_q <= '0;
                    end
                    WAIT_PMA: if (txpma_s && rxpma_s) begin
                        state_q <= SETTLE;
                        outs_q  <= state_outs(SETTLE);
                        timer_q <= '0;
                    end else if (timer_q >= PMA_TO) begin
                        state_q <= fail_state;
                        outs_q  <= state_outs(fail_state);
                        retry_q <= retry_inc;
                        timer_q <= '0;
                    end
                    SETTLE: if (timer_q >= SETTLE_LAST) begin
                        state_q <= WAIT_DONE;
                        outs_q  <= state_outs(WAIT_DONE);
                        timer_q <= '0;
                    end
                    WAIT_DONE: if (txd_s && rxd_s) begin
                        state_q <= UP;
                        outs_q  <= state_outs(UP);
                        retry_q <= '0;
                        timer_q <= '0;
                    end else if (timer_q >= DONE_TO) begin
                        state_q <= fail_state;
                        outs_q  <= state_outs(fail_state);
                        retry_q <= retry_inc;
                        timer_q <= '0;
                    end
                    UP: if (!txd_s || !txpma_s || !rxpma_s) begin
                        state_q    <= fail_state;
                        outs_q     <= state_outs(fail_state);
                        retry_q    <= retry_inc;
                        timer_q    <= '0;
                        rx_pulse_q <= 1'b0;
                    end else if (rx_pulse_q) begin
                        if (timer_q >= PULSE_LAST) begin
                            state_q    <= RX_RECOVER;
                            outs_q     <= state_outs(RX_RECOVER);
                            timer_q    <= '0;
                            rx_pulse_q <= 1'b0;
                        end
                    end else if (!rxd_s) begin
                        // Rx-only recovery: link is reported down for the whole pulse.
                        rx_pulse_q     <= 1'b1;
                        timer_q        <= '0;
                        outs_q.rx_dp   <= 1'b1;
                        outs_q.link_up <= 1'b0;
                    end
                    RX_RECOVER: if (rxd_s) begin
                        state_q <= UP;
                        outs_q  <= state_outs(UP);
                        timer_q <= '0;
                    end else if (timer_q >= DONE_TO) begin
                        state_q <= fail_state;
                        outs_q  <= state_outs(fail_state);
                        retry_q <= retry_inc;
                        timer_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gt.gtwiz_reset_all_out                 = outs_q.reset_all;
    assign gt.gtwiz_reset_tx_pll_and_datapath_out = outs_q.tx_pll_dp;
    assign gt.gtwiz_reset_rx_pll_and_datapath_out = outs_q.rx_pll_dp;
    assign gt.gtwiz_reset_tx_datapath_out         = 1'b0;
    assign gt.gtwiz_reset_rx_datapath_out         = outs_q.rx_dp;
    assign gt.gtwiz_userclk_tx_active_out         = outs_q.usrclk_active;
    assign gt.gtwiz_userclk_rx_active_out         = outs_q.usrclk_active;
    assign gt.link_up                             = outs_q.link_up;
    assign gt.fault                               = outs_q.fault;
    assign gt.retry_count                         = retry_q;
    assign gt.state_out                           = state_q;
    assign gt.rx_cdr_stable                       = cdr_s;

endmodule

// File: tb/tb_gty_reset_sequencer.sv
// Directed bench for gty_reset_sequencer with shortened timing and hand-computed expectations.
module tb_gty_reset_sequencer;

    logic aclk;
    logic aresetn;
    int   checks;
    int   failures;

    gty_reset_sequencer_if gt ();

    gty_reset_sequencer #(
        .RESET_PULSE_CYCLES   (4),
        .USRCLK_SETTLE_CYCLES (8),
        .PMA_TIMEOUT_CYCLES   (100),
        .DONE_TIMEOUT_CYCLES  (200),
        .MAX_RETRIES          (3),
        .CNT_W                (24)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .gt      (gt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (gt.state_out == s) break;
            tick();
        end
        chk(tag, gt.state_out, s);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, entries, pma_cyc, rxdp, lu_low, ra_seen, lat, seen;
        logic [2:0] prev;
        checks   = 0;
        failures = 0;

        // Reset with a request held high across it
        aresetn = 1'b0;
        gt.sw_reset_req = 1'b1;
        gt.gtpowergood_in = 1'b0;
        gt.txpmaresetdone_in = 1'b0;
        gt.rxpmaresetdone_in = 1'b0;
        gt.gtwiz_reset_tx_done_in = 1'b0;
        gt.gtwiz_reset_rx_done_in = 1'b0;
        gt.gtwiz_reset_rx_cdr_stable_in = 1'b0;
        repeat (5) tick();
        chk("rst_reset_all", gt.gtwiz_reset_all_out, 1);
        chk("rst_usrclk_tx", gt.gtwiz_userclk_tx_active_out, 0);
        chk("rst_pll_tx", gt.gtwiz_reset_tx_pll_and_datapath_out, 0);
        chk("rst_link_up", gt.link_up, 0);
        chk("rst_fault", gt.fault, 0);
        chk("rst_retry", gt.retry_count, 0);
        chk("rst_state", gt.state_out, 0);
        aresetn = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (gt.state_out != 3'd0) seen = 1;
        end
        chk("held_req_no_fire", seen, 0);
        gt.sw_reset_req = 1'b0;
        tick();
        tick();

        // Nominal bring-up
        gt.gtpowergood_in = 1'b1;
        wait_state(3'd1, 10, "nom_enter_rst_all");
        chk("nom_pll_tx", gt.gtwiz_reset_tx_pll_and_datapath_out, 1);
        chk("nom_pll_rx", gt.gtwiz_reset_rx_pll_and_datapath_out, 1);
        n = 0;
        while (gt.state_out == 3'd1 && n < 20) begin
            if (gt.gtwiz_reset_all_out !== 1'b1) n = 100;
            n++;
            tick();
        end
        chk("nom_rst_all_len", n, 4);
        chk("nom_rst_all_low", gt.gtwiz_reset_all_out, 0);
        chk("nom_state_pma", gt.state_out, 2);
        repeat (20) tick();
        gt.txpmaresetdone_in = 1'b1;
        gt.rxpmaresetdone_in = 1'b1;
        wait_state(3'd3, 10, "nom_enter_settle");
        n = 0;
        while (gt.state_out == 3'd3 && n < 30) begin
            if (gt.gtwiz_userclk_tx_active_out !== 1'b0) n = 100;
            n++;
            tick();
        end
        chk("nom_settle_len", n, 8);
        chk("nom_usrclk_tx", gt.gtwiz_userclk_tx_active_out, 1);
        chk("nom_usrclk_rx", gt.gtwiz_userclk_rx_active_out, 1);
        repeat (30) tick();
        gt.gtwiz_reset_tx_done_in = 1'b1;
        gt.gtwiz_reset_rx_done_in = 1'b1;
        wait_state(3'd5, 10, "nom_enter_up");
        chk("nom_link_up", gt.link_up, 1);
        chk("nom_retry", gt.retry_count, 0);
        chk("nom_tx_dp", gt.gtwiz_reset_tx_datapath_out, 0);

        // Rx-only recovery
        rxdp = 0; lu_low = 0; ra_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (gt.gtwiz_reset_rx_datapath_out) rxdp++;
            if (!gt.link_up) lu_low = 1;
            if (gt.gtwiz_reset_all_out) ra_seen = 1;
            if (i == 0) gt.gtwiz_reset_rx_done_in = 1'b0;
            if (i == 20) gt.gtwiz_reset_rx_done_in = 1'b1;
            tick();
        end
        chk("rx_dp_len", rxdp, 4);
        chk("rx_link_dropped", lu_low, 1);
        chk("rx_no_reset_all", ra_seen, 0);
        chk("rx_back_up", gt.state_out, 5);
        chk("rx_link_up", gt.link_up, 1);

        // Powergood loss while up
        gt.gtpowergood_in = 1'b0;
        lat = 99;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (gt.state_out == 3'd0) begin
                lat = i;
                break;
            end
        end
        chk("pg_loss_within_3", lat <= 3, 1);
        chk("pg_loss_usrclk", gt.gtwiz_userclk_tx_active_out, 0);
        chk("pg_loss_reset_all", gt.gtwiz_reset_all_out, 1);
        chk("pg_loss_retry", gt.retry_count, 0);
        tick();
        gt.gtpowergood_in = 1'b1;
        wait_state(3'd5, 60, "pg_rebringup_up");
        chk("pg_rebringup_link", gt.link_up, 1);

        // PMA timeout to FAULT, started by a request so the retry count begins at 0
        gt.txpmaresetdone_in = 1'b0;
        gt.rxpmaresetdone_in = 1'b0;
        gt.gtwiz_reset_tx_done_in = 1'b0;
        gt.gtwiz_reset_rx_done_in = 1'b0;
        gt.sw_reset_req = 1'b1;
        n = 0; entries = 0; pma_cyc = 0;
        prev = gt.state_out;
        for (int i = 0; i < 800; i++) begin
            if (gt.state_out == 3'd7) break;
            if (gt.state_out == 3'd1) n++;
            if (gt.state_out == 3'd1 && prev != 3'd1) entries++;
            if (gt.state_out == 3'd2) pma_cyc++;
            prev = gt.state_out;
            if (i == 10) gt.sw_reset_req = 1'b0;
            tick();
        end
        chk("pto_pulses", entries, 3);
        chk("pto_rst_cycles", n, 12);
        chk("pto_pma_cycles", pma_cyc, 303);
        chk("pto_fault", gt.fault, 1);
        chk("pto_state", gt.state_out, 7);
        chk("pto_retry", gt.retry_count, 3);
        chk("pto_reset_all", gt.gtwiz_reset_all_out, 1);

        // FAULT holds until a request
        gt.txpmaresetdone_in = 1'b1;
        gt.rxpmaresetdone_in = 1'b1;
        gt.gtwiz_reset_tx_done_in = 1'b1;
        gt.gtwiz_reset_rx_done_in = 1'b1;
        repeat (20) tick();
        chk("fault_sticky", gt.state_out, 7);
        gt.sw_reset_req = 1'b1;
        wait_state(3'd1, 6, "fault_exit_state");
        chk("fault_exit_retry", gt.retry_count, 0);
        chk("fault_exit_flag", gt.fault, 0);
        wait_state(3'd5, 60, "fault_exit_up");
        gt.sw_reset_req = 1'b0;

        // Request edge lands on the same cycle as a done timeout
        gt.gtwiz_reset_tx_done_in = 1'b0;
        gt.gtwiz_reset_rx_done_in = 1'b0;
        wait_state(3'd4, 60, "sim_enter_wait_done");
        chk("sim_retry_before", gt.retry_count, 1);
        repeat (198) tick();
        gt.sw_reset_req = 1'b1;
        tick();
        tick();
        chk("sim_still_wait_done", gt.state_out, 4);
        tick();
        chk("sim_state_rst_all", gt.state_out, 1);
        chk("sim_retry_cleared", gt.retry_count, 0);
        chk("sim_usrclk_off", gt.gtwiz_userclk_rx_active_out, 0);
        gt.sw_reset_req = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
